// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the master that did not
// finish last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) gnt_idx = ~last;
    else              gnt_idx = req[1];
    gnt = 2'b00;
    if (req != 2'b00) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI4-Lite arbiter onto one slave: one transaction in flight,
// round-robin per transaction, forced response if the slave hangs.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  // master 1
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [STRB_W-1:0] s1_wstrb,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  // slave
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              timeout_err
);

  // Counter holds up to TIMEOUT+1 so "forced" stays true after the first forced cycle.
  localparam int              CNT_W  = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam bit              TMO_EN = (TIMEOUT != 0);

  logic [1:0][ADDR_W-1:0] s_awaddr, s_araddr;
  logic [1:0][DATA_W-1:0] s_wdata, s_rdata;
  logic [1:0][STRB_W-1:0] s_wstrb;
  logic [1:0] s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic [1:0] s_awready, s_wready, s_arready, s_bvalid, s_rvalid;

  assign s_awaddr  = {s1_awaddr,  s0_awaddr};
  assign s_araddr  = {s1_araddr,  s0_araddr};
  assign s_wdata   = {s1_wdata,   s0_wdata};
  assign s_wstrb   = {s1_wstrb,   s0_wstrb};
  assign s_awvalid = {s1_awvalid, s0_awvalid};
  assign s_wvalid  = {s1_wvalid,  s0_wvalid};
  assign s_arvalid = {s1_arvalid, s0_arvalid};
  assign s_bready  = {s1_bready,  s0_bready};
  assign s_rready  = {s1_rready,  s0_rready};

  assign s0_awready = s_awready[0];
  assign s1_awready = s_awready[1];
  assign s0_wready  = s_wready[0];
  assign s1_wready  = s_wready[1];
  assign s0_arready = s_arready[0];
  assign s1_arready = s_arready[1];
  assign s0_bvalid  = s_bvalid[0];
  assign s1_bvalid  = s_bvalid[1];
  assign s0_rvalid  = s_rvalid[0];
  assign s1_rvalid  = s_rvalid[1];
  assign s0_rdata   = s_rdata[0];
  assign s1_rdata   = s_rdata[1];

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              m_awvalid_q, m_awvalid_d;
  logic              m_wvalid_q, m_wvalid_d;
  logic              m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;

  assign m_awaddr    = m_awaddr_q;
  assign m_awvalid   = m_awvalid_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;
  assign m_wvalid    = m_wvalid_q;
  assign m_araddr    = m_araddr_q;
  assign m_arvalid   = m_arvalid_q;
  assign timeout_err = timeout_err_q;

  logic [1:0] wreq, req, gnt;
  logic       gnt_idx, pick_wr, forced, aw_hs, w_hs, ar_hs, rsp_in;

  assign wreq = s_awvalid & s_wvalid;
  assign req  = wreq | s_arvalid;

  rr_arb2 u_rr (
    .req     (req),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A master with both a write and a read pending is served its write first.
  assign pick_wr = wreq[gnt_idx];
  assign forced  = TMO_EN && (cnt_q >= TMO);
  assign aw_hs   = m_awvalid_q & m_awready;
  assign w_hs    = m_wvalid_q & m_wready;
  assign ar_hs   = m_arvalid_q & m_arready;
  assign rsp_in  = (state_q == WR_RSP) ? m_bvalid : m_rvalid;

  // Upstream handshakes and response forwarding through the winner mux.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Late responses from a timed-out transaction are swallowed here.
        m_bready  = 1'b1;
        m_rready  = 1'b1;
        s_awready = gnt & {2{pick_wr}};
        s_wready  = gnt & {2{pick_wr}};
        s_arready = gnt & {2{~pick_wr}};
      end
      WR_RSP: begin
        s_bvalid[win_q] = forced | m_bvalid;
        m_bready        = ~forced & s_bready[win_q];
      end
      RD_RSP: begin
        s_rvalid[win_q] = forced | m_rvalid;
        s_rdata[win_q]  = forced ? DATA_W'(TIMEOUT_RDATA) : m_rdata;
        m_rready        = ~forced & s_rready[win_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    win_d         = win_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    m_awvalid_d   = m_awvalid_q;
    m_wvalid_d    = m_wvalid_q;
    m_arvalid_d   = m_arvalid_q;
    m_awaddr_d    = m_awaddr_q;
    m_araddr_d    = m_araddr_q;
    m_wdata_d     = m_wdata_q;
    m_wstrb_d     = m_wstrb_q;
    cnt_d         = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d = gnt_idx;
          if (pick_wr) begin
            m_awaddr_d  = s_awaddr[gnt_idx];
            m_wdata_d   = s_wdata[gnt_idx];
            m_wstrb_d   = s_wstrb[gnt_idx];
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            state_d     = WR_REQ;
          end else begin
            m_araddr_d  = s_araddr[gnt_idx];
            m_arvalid_d = 1'b1;
            state_d     = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          m_awvalid_d = 1'b0;
          aw_done_d   = 1'b1;
        end
        if (w_hs) begin
          m_wvalid_d = 1'b0;
          w_done_d   = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RSP;
      end
      RD_REQ: begin
        if (ar_hs) begin
          m_arvalid_d = 1'b0;
          state_d     = RD_RSP;
        end
      end
      WR_RSP, RD_RSP: begin
        if ((s_bvalid[win_q] && s_bready[win_q]) || (s_rvalid[win_q] && s_rready[win_q])) begin
          last_d  = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q;
          if (TMO_EN && !rsp_in && cnt_q <= TMO) cnt_d = cnt_q + 1'b1;
          timeout_err_d = TMO_EN && (cnt_d == TMO) && (cnt_q != TMO);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      win_q         <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      m_awvalid_q   <= 1'b0;
      m_wvalid_q    <= 1'b0;
      m_arvalid_q   <= 1'b0;
      m_awaddr_q    <= '0;
      m_araddr_q    <= '0;
      m_wdata_q     <= '0;
      m_wstrb_q     <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      win_q         <= win_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      m_awvalid_q   <= m_awvalid_d;
      m_wvalid_q    <= m_wvalid_d;
      m_arvalid_q   <= m_arvalid_d;
      m_awaddr_q    <= m_awaddr_d;
      m_araddr_q    <= m_araddr_d;
      m_wdata_q     <= m_wdata_d;
      m_wstrb_q     <= m_wstrb_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
